// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver, 8N1/8E1/8O1, run-time baud select.
// Majority vote on ticks 7/8/9 of each bit, one-clk strobe per frame.
module uart_rx_os16 #(
    parameter int CLK_FREQ = 50000000,
    parameter int OS_RATE  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [1:0] baud_select,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    function automatic int div_of(input int baud);
        return (CLK_FREQ + baud * (OS_RATE / 2)) / (baud * OS_RATE);
    endfunction

    localparam logic [15:0] DIV_MAX0 = 16'(div_of(9600) - 1);
    localparam logic [15:0] DIV_MAX1 = 16'(div_of(19200) - 1);
    localparam logic [15:0] DIV_MAX2 = 16'(div_of(38400) - 1);
    localparam logic [15:0] DIV_MAX3 = 16'(div_of(57600) - 1);
    localparam logic [3:0]  T_DEC    = 4'(OS_RATE / 2);
    localparam logic [3:0]  T_LAST   = 4'(OS_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state_q;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [1:0]  baud_q;
    logic        pen_q, podd_q;
    logic [15:0] div_cnt_q;
    logic [3:0]  tick_cnt_q;
    logic [1:0]  smp_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        perr_q;
    logic [7:0]  data_out_q;
    logic        data_valid_q, parity_err_q, frame_err_q, busy_q;

    logic [15:0] div_max;
    logic        tick, dec, last, maj, start_det;

    always_comb begin
        div_max = DIV_MAX0;
        unique case (baud_q)
            2'd0: div_max = DIV_MAX0;
            2'd1: div_max = DIV_MAX1;
            2'd2: div_max = DIV_MAX2;
            2'd3: div_max = DIV_MAX3;
            default: div_max = DIV_MAX0;
        endcase
    end

    assign tick      = (state_q != S_IDLE) && (div_cnt_q == div_max);
    // tick_cnt_q holds the previous tick index; the next tick is +1
    assign dec       = tick && (tick_cnt_q == T_DEC);
    assign last      = tick && (tick_cnt_q == T_LAST);
    assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q)
                     | (smp_q[1] & rx_s_q);
    assign start_det = (state_q == S_IDLE) && rx_prev_q && !rx_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            baud_q       <= 2'd0;
            pen_q        <= 1'b0;
            podd_q       <= 1'b0;
            div_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            smp_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_prev_q    <= rx_s_q;
            data_valid_q <= 1'b0;

            if (state_q != S_IDLE) begin
                if (tick) begin
                    div_cnt_q  <= '0;
                    tick_cnt_q <= tick_cnt_q + 4'd1;
                end else begin
                    div_cnt_q <= div_cnt_q + 16'd1;
                end
            end

            if (tick && (tick_cnt_q == T_DEC - 4'd2 ||
                         tick_cnt_q == T_DEC - 4'd1)) begin
                smp_q <= {smp_q[0], rx_s_q};
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start_det) begin
                        state_q    <= S_START;
                        busy_q     <= 1'b1;
                        baud_q     <= baud_select;
                        pen_q      <= parity_en;
                        podd_q     <= parity_odd;
                        div_cnt_q  <= '0;
                        tick_cnt_q <= '0;
                    end
                end
                S_START: begin
                    if (dec && maj) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                        perr_q    <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (dec) shift_q <= {maj, shift_q[7:1]};
                    if (last) begin
                        if (bit_cnt_q == 3'd7)
                            state_q <= pen_q ? S_PARITY : S_STOP;
                        else
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (dec) perr_q <= maj != ((^shift_q) ^ podd_q);
                    if (last) state_q <= S_STOP;
                end
                S_STOP: begin
                    // leave at mid-bit so a back-to-back start edge is seen
                    if (dec) begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        data_out_q   <= shift_q;
                        parity_err_q <= perr_q;
                        frame_err_q  <= !maj;
                        data_valid_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: directed plan plus random frames against
// a frame-level model of what each serial frame should yield.
`timescale 1ns/1ps
module tb_uart_rx_os16;

    localparam int  CLK_HZ = 3686400;
    localparam real HALF   = 1.0e9 / CLK_HZ / 2.0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] baud_select = 2'd0;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, busy;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  abort = 1'b0;
    real t_valid = 0.0;
    real t0, lat;

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    uart_rx_os16 #(.CLK_FREQ(CLK_HZ), .OS_RATE(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .baud_select(baud_select),
        .parity_en(parity_en),
        .parity_odd(parity_odd),
        .data_out(data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .busy(busy)
    );

    initial forever #(HALF) clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            got_q.push_back({frame_err, parity_err, data_out});
            t_valid = $realtime;
        end
    end

    function automatic real bit_ns(input logic [1:0] sel);
        int baud;
        baud = (sel == 2'd0) ? 9600 : (sel == 2'd1) ? 19200 :
               (sel == 2'd2) ? 38400 : 57600;
        return 1.0e9 / baud;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame and records what the receiver should report.
    task automatic send(input logic [7:0] b, input logic [1:0] sel,
                        input bit pen, input bit podd, input bit pflip,
                        input bit stop, input real skew, input bit mess,
                        input bit idle);
        logic bits[11];
        logic pbit;
        int   n;
        real  bt;
        bt = bit_ns(sel) * skew;
        baud_select = sel;
        parity_en = pen;
        parity_odd = podd;
        pbit = (^b) ^ podd ^ pflip;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        n = 9;
        if (pen) begin
            bits[9] = pbit;
            n = 10;
        end
        bits[n] = stop;
        n = n + 1;
        for (int i = 0; i < n; i++) begin
            if (abort) begin
                rx = 1'b1;
                return;
            end
            rx = bits[i];
            if (mess && i == 1) begin
                parity_odd = !podd;
                baud_select = ~sel;
            end
            #(bt);
        end
        baud_select = sel;
        parity_odd = podd;
        exp_q.push_back({!stop,
                         pen && (pbit != ((^b) ^ podd)), b});
        if (idle) begin
            rx = 1'b1;
            #(bt);
        end
    endtask

    task automatic check_all(input string tag);
        logic [9:0] g, e;
        chk({tag, ".count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, ".data"}, g[7:0], e[7:0]);
            chk({tag, ".perr"}, g[8], e[8]);
            chk({tag, ".ferr"}, g[9], e[9]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rb;
        logic [1:0] rs;
        bit rpen, rodd, rflip, rstop, rmess;

        repeat (5) @(posedge clk);
        #1;
        chk("rst.data", data_out, 8'h00);
        chk("rst.flags", {data_valid, parity_err, frame_err, busy}, 4'h0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        t0 = $realtime;
        send(8'h4D, 2'd0, 0, 0, 0, 1, 1.0, 0, 1);
        lat = t_valid - t0;
        chk("t1.latency", (lat > 992000.0 && lat < 1002000.0), 1);
        chk("t1.busy", busy, 1'b0);
        check_all("t1");
        chk("t1.hold", data_out, 8'h4D);

        send(8'hB3, 2'd1, 1, 0, 0, 1, 1.0, 0, 1);
        check_all("t2.even_ok");
        send(8'hB3, 2'd1, 1, 0, 1, 1, 1.0, 1, 1);
        check_all("t2.even_bad");
        send(8'hB3, 2'd1, 1, 1, 0, 1, 1.0, 0, 1);
        check_all("t2.odd_ok");

        send(8'h5A, 2'd0, 0, 0, 0, 0, 1.0, 0, 0);
        check_all("t3.ferr");
        #(20.0 * bit_ns(2'd0));
        check_all("t3.held_low");
        rx = 1'b1;
        #(bit_ns(2'd0));
        send(8'h0F, 2'd0, 0, 0, 0, 1, 1.0, 0, 1);
        check_all("t3.recover");

        baud_select = 2'd0;
        rx = 1'b0;
        #(0.27 * bit_ns(2'd0));
        chk("t4.busy_hi", busy, 1'b1);
        rx = 1'b1;
        #(bit_ns(2'd0));
        chk("t4.busy_lo", busy, 1'b0);
        check_all("t4.false");
        send(8'hC3, 2'd0, 0, 0, 0, 1, 1.0, 0, 1);
        check_all("t4.next");

        send(8'h55, 2'd3, 0, 0, 0, 1, 1.02, 0, 0);
        send(8'hAA, 2'd3, 0, 0, 0, 1, 0.98, 0, 1);
        check_all("t5.b2b");

        send(8'h3C, 2'd1, 1, 0, 1, 0, 1.0, 0, 1);
        check_all("t6.pre");
        fork
            send(8'h99, 2'd0, 0, 0, 0, 1, 1.0, 0, 0);
            begin
                #(4.5 * bit_ns(2'd0));
                chk("t6.busy_mid", busy, 1'b1);
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                chk("t6.rst_data", data_out, 8'h00);
                chk("t6.rst_flags",
                    {data_valid, parity_err, frame_err, busy}, 4'h0);
                #(bit_ns(2'd0));
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        rx = 1'b1;
        #(bit_ns(2'd0));
        check_all("t6.aborted");
        send(8'h81, 2'd0, 0, 0, 0, 1, 1.0, 0, 1);
        check_all("t6.after");

        for (int k = 0; k < 8; k++) begin
            rb    = 8'($urandom);
            rs    = 2'($urandom_range(1, 3));
            rpen  = 1'($urandom);
            rodd  = 1'($urandom);
            rflip = 1'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rmess = 1'($urandom);
            send(rb, rs, rpen, rodd, rflip, rstop, 1.0, rmess, 1);
            check_all($sformatf("rnd%0d", k));
            chk($sformatf("rnd%0d.hold", k), data_out, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
Oversampling UART receiver, the far-end counterpart of the team's UART transmitter. Recovers 8N1 / 8E1 / 8O1 frames from the serial line at 16x oversampling with a baud rate selected at run time. Presents each byte with a one-cycle valid strobe plus parity and framing status. Sits between the pin (or the transmitter's serial output in loopback benches) and the byte-level consumer.

Parameters:
CLK_FREQ  50000000  system clock frequency in Hz
OS_RATE  16  oversampling ticks per bit (fixed design point; other values unsupported)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, LSB first
baud_select  input  2  00=9600, 01=19200, 10=38400, 11=57600
parity_en  input  1  1 = a parity bit follows the data bits
parity_odd  input  1  0 = even parity, 1 = odd parity (ignored if parity_en=0)
data_out  output  8  last received byte
data_valid  output  1  one-clk pulse: data_out, parity_err and frame_err updated
parity_err  output  1  parity mismatch on last frame
frame_err  output  1  stop bit sampled low on last frame
busy  output  1  frame reception in progress

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM=IDLE; synchronizer flops preset to 1.
- rx passes a 2-flop synchronizer; all logic uses the synced value (rx_s).
- Tick generator: divisor = (CLK_FREQ + BAUD*8) / (BAUD*16), rounded to nearest. At 50 MHz: 326 / 163 / 81 / 54. One-clk tick pulse per divisor count.
- baud_select, parity_en and parity_odd are latched on start detection and held for the whole frame; changes mid-frame take effect on the next frame.
- Divider and tick counter (0..15) clear on start detection, so the tick phase aligns to the falling edge.
- Bit decision: majority of rx_s sampled on ticks 7, 8 and 9. Decision is made at tick 9; the bit ends at tick 15.
- FSM:
  - IDLE: busy=0. A 1->0 transition on rx_s goes to START. A line held low never retriggers; rx_s must return high first.
  - START: if the majority is 1 at tick 9, this is a false start: go to IDLE and emit no strobe. Otherwise continue to DATA at the bit boundary.
  - DATA: 8 bits shifted LSB first. After bit 7, go to PARITY if parity_en, else STOP.
  - PARITY: expected bit = XOR(data) ^ parity_odd. A mismatch sets the internal parity flag.
  - STOP: decide at tick 9; frame flag = (bit == 0). Go to IDLE at tick 9, not tick 15, so a back-to-back start edge is caught.
- Output update, on the clock after the STOP decision:
  - data_out, parity_err and frame_err load together; data_valid=1 for exactly that clk.
  - All three status values hold until the next data_valid.
  - The byte is delivered even when parity_err or frame_err is set.
  - parity_err=0 whenever parity_en was 0.
- busy=1 from the start-detection clk until the FSM returns to IDLE.
- Reset mid-frame: frame abandoned immediately, no strobe, outputs cleared to 0.
- Frame latency (start edge to data_valid), 8N1: about 9.56 bit times plus 3 clks. At 9600 with divisor 326: about 49,860 clks (~997 us).

Test Plan:
1. 9600, 8N1, byte 0x4D, stop=1 -> exactly one data_valid pulse ~997 us after the start edge; data_out=0x4D; parity_err=0; frame_err=0; busy=0 afterwards.
2. 19200, even parity, byte 0xB3 with parity bit 1 -> data_out=0xB3, parity_err=0. Repeat with parity bit 0 -> data_out=0xB3, parity_err=1. Odd parity with parity bit 0 -> parity_err=0.
3. 9600, 8N1, byte 0x5A with stop bit 0 -> data_valid pulse, data_out=0x5A, frame_err=1. Hold rx low for a further 2 frame times -> no additional data_valid. Then rx high for 1 bit followed by frame 0x0F -> data_out=0x0F, frame_err=0.
4. 9600, rx low for 1300 clks (~4 ticks) then high -> busy pulses, no data_valid, FSM back in IDLE; next 0xC3 frame is received correctly.
5. 57600, 8N1, 0x55 then 0xAA back-to-back (single stop bit, no idle gap), with ±2% bit-time skew on the stimulus -> two data_valid pulses, 0x55 then 0xAA, no errors.
6. rst_n pulsed low during DATA bit 3 of a 9600 frame -> data_out=0, flags=0 and busy=0 within the same clk (async). Frame 0x81 after release -> data_out=0x81.
